// File: rtl/mp_add_sequencer.sv
// Multi-precision add front-end: walks WORDS chunks of W bits through an external
// registered adder stage, least significant first, chaining the carry between chunks.
module mp_add_sequencer #(
  parameter int W         = 64,
  parameter int WORDS     = 4,
  parameter int ADDER_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WORDS*W-1:0] a,
  input  logic [WORDS*W-1:0] b,
  input  logic               cin,
  output logic               busy,
  output logic               done,
  output logic [WORDS*W-1:0] sum,
  output logic               cout,
  output logic [W-1:0]       add_a,
  output logic [W-1:0]       add_b,
  output logic               add_cin,
  input  logic [W-1:0]       add_sum,
  input  logic               add_cout
);

  localparam int N    = WORDS * W;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNTW = $clog2(ADDER_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Handshake: start is a level sampled only in IDLE; busy is high from the cycle
  // after acceptance through the DONE cycle; done pulses for exactly one cycle.
  state_t            state, state_n;
  logic [N-1:0]      a_lat, a_lat_n, b_lat, b_lat_n;
  logic [IDXW-1:0]   idx, idx_n, idx_inc;
  logic [CNTW-1:0]   cnt, cnt_n;
  logic              carry, carry_n;
  logic [N-1:0]      sum_r, sum_n;
  logic              cout_r, cout_n;
  logic [W-1:0]      add_a_r, add_a_n, add_b_r, add_b_n;
  logic              add_cin_r, add_cin_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_lat     <= '0;
      b_lat     <= '0;
      idx       <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      sum_r     <= '0;
      cout_r    <= 1'b0;
      add_a_r   <= '0;
      add_b_r   <= '0;
      add_cin_r <= 1'b0;
    end else begin
      state     <= state_n;
      a_lat     <= a_lat_n;
      b_lat     <= b_lat_n;
      idx       <= idx_n;
      cnt       <= cnt_n;
      carry     <= carry_n;
      sum_r     <= sum_n;
      cout_r    <= cout_n;
      add_a_r   <= add_a_n;
      add_b_r   <= add_b_n;
      add_cin_r <= add_cin_n;
    end
  end

  // Adder operands are loaded on the edge that enters ISSUE so they are already
  // valid while ISSUE is current; a chunk then costs exactly 1+ADDER_LAT cycles.
  always_comb begin
    state_n   = state;
    a_lat_n   = a_lat;
    b_lat_n   = b_lat;
    idx_n     = idx;
    cnt_n     = cnt;
    carry_n   = carry;
    sum_n     = sum_r;
    cout_n    = cout_r;
    add_a_n   = add_a_r;
    add_b_n   = add_b_r;
    add_cin_n = add_cin_r;
    idx_inc   = idx + 1'b1;
    case (state)
      IDLE: begin
        if (start) begin
          a_lat_n   = a;
          b_lat_n   = b;
          idx_n     = '0;
          carry_n   = cin;
          sum_n     = '0;
          cout_n    = 1'b0;
          add_a_n   = a[W-1:0];
          add_b_n   = b[W-1:0];
          add_cin_n = cin;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_n   = CNTW'(ADDER_LAT);
        state_n = WAIT;
      end
      WAIT: begin
        if (cnt == CNTW'(1)) begin
          sum_n[int'(idx)*W +: W] = add_sum;
          carry_n = add_cout;
          if (idx == IDXW'(WORDS - 1)) begin
            cout_n  = add_cout;
            state_n = DONE;
          end else begin
            idx_n     = idx_inc;
            add_a_n   = a_lat[int'(idx_inc)*W +: W];
            add_b_n   = b_lat[int'(idx_inc)*W +: W];
            add_cin_n = add_cout;
            state_n   = ISSUE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DONE: begin
        add_a_n   = '0;
        add_b_n   = '0;
        add_cin_n = 1'b0;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign sum     = sum_r;
  assign cout    = cout_r;
  assign add_a   = add_a_r;
  assign add_b   = add_b_r;
  assign add_cin = add_cin_r;

endmodule
